// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port clocked data memory.
// One access in flight at a time; out-of-range addresses are acked with an error, memory untouched.
module dmem_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_en,
  output logic              mem_rnw,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp, StErr} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              grant;
  logic [ADDR_W-1:0] sel_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    // On a tie the port that did not win last time gets the grant.
    grant        = (req0 && req1) ? ~last_owner_q : req1;
    sel_addr     = grant ? addr1 : addr0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          owner_d      = grant;
          last_owner_d = grant;
          we_d         = grant ? we1 : we0;
          addr_d       = sel_addr;
          wdata_d      = grant ? wdata1 : wdata0;
          state_d      = (sel_addr >= ADDR_W'(MEM_WORDS)) ? StErr : StIssue;
        end
      end
      StIssue: state_d = StResp;
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_en    = (state_q == StIssue);
    mem_rnw   = mem_en ? ~we_q : 1'b1;
    mem_addr  = mem_en ? addr_q : '0;
    mem_wdata = (mem_en && we_q) ? wdata_q : '0;
    busy      = (state_q != StIdle);
    ack0      = (state_q == StResp || state_q == StErr) && !owner_q;
    ack1      = (state_q == StResp || state_q == StErr) && owner_q;
    err0      = (state_q == StErr) && !owner_q;
    err1      = (state_q == StErr) && owner_q;
    rdata0    = (state_q == StResp && !owner_q) ? mem_rdata : '0;
    rdata1    = (state_q == StResp && owner_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table of single accesses plus
// contention and mid-access reset sequences, against a behavioural memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_rnw, busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en),
    .mem_rnw(mem_rnw), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Single-port memory with registered output; a write echoes its data.
  logic [31:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rnw) mem_rdata <= mem[mem_addr[4:0]];
      else begin
        mem[mem_addr[4:0]] <= mem_wdata;
        mem_rdata          <= mem_wdata;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at the ack negedge with req dropped.
  task automatic do_access(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                           output logic er, output int en_cnt, output int other);
    lat = 0; rd = 32'h0; er = 1'b0; en_cnt = 0; other = 0;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_en) en_cnt++;
      if (port ? (ack0 || err0 || rdata0 != 0) : (ack1 || err1 || rdata1 != 0)) other++;
      if (port ? ack1 : ack0) begin
        lat = c;
        rd  = port ? rdata1 : rdata0;
        er  = port ? err1 : err0;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int          lat, en_cnt, other;
    logic [31:0] rd;
    logic        er;
    int          n_ack0;

    vecs[0]  = '{1'b0, 1'b1, 32'd5,         32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'd5,         32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'd0,         32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'd31,        32'h00000001, 32'h00000001, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'd0,         32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'd31,        32'h0,        32'h00000001, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'd0,         32'h00000001, 32'h00000001, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'd31,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'd0,         32'h0,        32'h00000001, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'd31,        32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 32'd32,        32'hBAD0BAD0, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'd0,         32'h0,        32'h00000001, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h80000000,  32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b1, 1'b1, 32'd1,         32'h11111111, 32'h11111111, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'd2,         32'h22222222, 32'h22222222, 1'b0};

    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_acks", {31'h0, ack0 | ack1 | err0 | err1}, 32'h0);
    chk("reset_rdata", rdata0 | rdata1, 32'h0);
    chk("reset_mem_ctl", {29'h0, mem_en, mem_rnw, busy}, 32'h2);
    chk("reset_mem_bus", mem_addr | mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, er, en_cnt, other);
      chk($sformatf("v%0d_latency", i), 32'(lat), vecs[i].exp_err ? 32'd1 : 32'd2);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      chk($sformatf("v%0d_mem_en_cycles", i), 32'(en_cnt), vecs[i].exp_err ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_other_port_quiet", i), 32'(other), 32'd0);
      @(negedge clk);
    end

    // Contention from reset: port 0 wins the first tie, then strict alternation.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 32'd1;
    req1 = 1; we1 = 0; addr1 = 32'd2;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("cont_c%0d_ack0_ack1_busy", c), {29'h0, ack0, ack1, busy},
          {29'h0, (c % 6) == 2, (c % 6) == 5, (c % 3) != 0});
      if (ack0) chk($sformatf("cont_c%0d_rdata0", c), rdata0, 32'h11111111);
      if (ack1) chk($sformatf("cont_c%0d_rdata1", c), rdata1, 32'h22222222);
    end
    req0 = 0; req1 = 0;
    @(negedge clk);

    // Reset during ISSUE of a port-0 read: dropped, never acked.
    req0 = 1; we0 = 0; addr0 = 32'd5;
    @(negedge clk);
    chk("rst_mid_issue_mem_en", {31'h0, mem_en}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_mid_async_ctl", {30'h0, mem_en, busy}, 32'h0);
    n_ack0 = 0;
    @(negedge clk);
    req0 = 0;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack0) n_ack0++;
    end
    chk("rst_mid_no_ack0", 32'(n_ack0), 32'd0);
    do_access(1'b1, 1'b0, 32'd5, 32'h0, lat, rd, er, en_cnt, other);
    chk("post_rst_p1_latency", 32'(lat), 32'd2);
    chk("post_rst_p1_rdata", rd, 32'hDEADBEEF);
    chk("post_rst_p1_err", {31'h0, er}, 32'h0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
